// File: rtl/sram_tester_pkg.sv
// Shared state/pattern types and the address-derived data pattern used by
// sram_mem_tester for both write generation and readback checking.
package sram_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_ADDR    = 2'd0,
    PAT_NADDR   = 2'd1,
    PAT_WALK1   = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_t;

  localparam int unsigned PAT_MAX_W = 64;

  // Result is masked to 'width' bits; callers truncate to their data width.
  function automatic logic [PAT_MAX_W-1:0] pattern_word(
    input logic [PAT_MAX_W-1:0] addr,
    input pattern_t             pat,
    input int unsigned          width
  );
    logic [PAT_MAX_W-1:0] mask;
    logic [PAT_MAX_W-1:0] word;
    mask = (width >= 32'd64) ? {PAT_MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
    case (pat)
      PAT_ADDR:    word = addr;
      PAT_NADDR:   word = ~addr;
      PAT_WALK1:   word = 64'd1 << (addr % 64'(width));
      PAT_CHECKER: word = addr[0] ? {32{2'b10}} : {32{2'b01}};
      default:     word = 64'd0;
    endcase
    return word & mask;
  endfunction

endpackage

// File: rtl/sram_mem_tester.sv
// Avalon-MM memory self-test initiator: writes an address-derived pattern over
// a window, reads it back one word at a time and reports the comparison result.
module sram_mem_tester
  import sram_tester_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_lo_i,
  input  logic [ADDR_W-1:0] addr_hi_i,
  input  logic [1:0]        pattern_i,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_write_o,
  output logic [DATA_W-1:0] avm_writedata_o,
  output logic              avm_read_o,
  input  logic              avm_waitrequest_i,
  input  logic [DATA_W-1:0] avm_readdata_i,
  input  logic              avm_readdatavalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              cfg_err_o,
  output logic              timeout_o,
  output logic [15:0]       err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_data_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_hi;
  pattern_t          r_pat;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first_addr;
  logic [DATA_W-1:0] r_first_data;
  logic              r_pass;
  logic              r_cfg_err;
  logic              r_timeout;
  logic [DATA_W-1:0] w_expect;
  logic              w_cfg_bad;
  logic              w_at_hi;
  logic              w_mismatch;
  logic              w_tmo_hit;
  logic              w_write;
  logic              w_read;

  assign w_expect   = DATA_W'(pattern_word(64'(r_addr), r_pat, DATA_W));
  assign w_cfg_bad  = (addr_hi_i < addr_lo_i);
  assign w_at_hi    = (r_addr == r_hi);
  assign w_mismatch = (avm_readdata_i != w_expect);
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Next-state and bus command decode.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_read      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_cfg_bad ? S_DONE : S_WR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        w_write = 1'b1;
        if (!avm_waitrequest_i && w_at_hi) begin
          w_state_nxt = S_RD_REQ;
        end else begin
          w_state_nxt = S_WR;
        end
      end
      S_RD_REQ: begin
        w_read = 1'b1;
        if (!avm_waitrequest_i) begin
          w_state_nxt = S_RD_WAIT;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid_i) begin
          w_state_nxt = w_at_hi ? S_DONE : S_RD_REQ;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address, timeout and result registers; pass is resolved as DONE is entered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr       <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_pat        <= PAT_ADDR;
      r_tmo_cnt    <= '0;
      r_err_cnt    <= 16'd0;
      r_first_addr <= '0;
      r_first_data <= '0;
      r_pass       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr       <= addr_lo_i;
            r_lo         <= addr_lo_i;
            r_hi         <= addr_hi_i;
            r_pat        <= pattern_t'(pattern_i);
            r_err_cnt    <= 16'd0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cfg_err    <= w_cfg_bad;
          end
        end
        S_WR: begin
          if (!avm_waitrequest_i) begin
            r_addr <= w_at_hi ? r_lo : r_addr + ADDR_W'(1);
          end
        end
        S_RD_REQ: r_tmo_cnt <= TMO_W'(1);
        S_RD_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (avm_readdatavalid_i) begin
            if (w_mismatch) begin
              if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
              end
              if (r_err_cnt == 16'd0) begin
                r_first_addr <= r_addr;
                r_first_data <= avm_readdata_i;
              end
            end
            if (w_at_hi) begin
              r_pass <= (r_err_cnt == 16'd0) && !w_mismatch;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign avm_address_o    = r_addr;
  assign avm_write_o      = w_write;
  assign avm_read_o       = w_read;
  assign avm_writedata_o  = w_write ? w_expect : '0;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);
  assign pass_o           = r_pass;
  assign cfg_err_o        = r_cfg_err;
  assign timeout_o        = r_timeout;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_addr;
  assign first_err_data_o = r_first_data;

endmodule

// File: tb/tb_sram_mem_tester.sv
// Directed bench for sram_mem_tester: an Avalon slave with a scoreboard that
// derives every expected bus cycle and result from the window and pattern.
module tb_sram_mem_tester;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        start;
  logic [17:0] addr_lo, addr_hi;
  logic [1:0]  pattern;
  logic [17:0] avm_address;
  logic        avm_write, avm_read;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = 16'h0000;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, cfg_err, timeout;
  logic [15:0] err_cnt;
  logic [17:0] first_err_addr;
  logic [15:0] first_err_data;

  sram_mem_tester #(.ADDR_W(18), .DATA_W(16), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .addr_lo_i(addr_lo), .addr_hi_i(addr_hi), .pattern_i(pattern),
    .avm_address_o(avm_address), .avm_write_o(avm_write),
    .avm_writedata_o(avm_writedata), .avm_read_o(avm_read),
    .avm_waitrequest_i(avm_waitrequest), .avm_readdata_i(avm_readdata),
    .avm_readdatavalid_i(avm_readdatavalid),
    .busy_o(busy), .done_o(done), .pass_o(pass), .cfg_err_o(cfg_err),
    .timeout_o(timeout), .err_cnt_o(err_cnt),
    .first_err_addr_o(first_err_addr), .first_err_data_o(first_err_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Scoreboard / slave state
  logic [15:0] mem [logic [17:0]];
  logic [63:0] m_hi, m_wr_next, m_rd_next;
  logic [1:0]  m_pat;
  int          m_wr_idx, m_start_cyc, m_acc_cyc, last_evt_cyc, m_lat, rd_lat;
  logic [15:0] m_err;
  bit          m_first_set, m_bus_ok, rand_wait, inject, no_resp;
  bit          spur_en, spur_next, rd_pend, prev_hold;
  logic [17:0] m_first_addr, rd_addr, p_addr;
  logic [15:0] m_first_data, p_data;
  logic        p_wr, p_rd;
  localparam logic [17:0] INJ_ADDR = 18'd5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected memory word straight from the pattern definitions (16-bit data).
  function automatic logic [15:0] exp_word(input logic [63:0] addr, input logic [1:0] pat);
    case (pat)
      2'd0:    return addr[15:0];
      2'd1:    return ~addr[15:0];
      2'd2:    return 16'h0001 << (addr % 64'd16);
      default: return addr[0] ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

  // Slave responder and per-cycle bus checker, active on the falling edge.
  initial begin : slave
    bit          wq;
    logic [15:0] rdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_pend = 1'b0; prev_hold = 1'b0; spur_next = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 16'h0000;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = 16'h0000;
        if (spur_next) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = 16'hDEAD;
          spur_next = 1'b0;
        end else if (rd_pend && !no_resp) begin
          rd_lat = rd_lat - 1;
          if (rd_lat == 0) begin
            rdata = mem.exists(rd_addr) ? mem[rd_addr] : 16'h0000;
            if (inject && rd_addr == INJ_ADDR) rdata = rdata ^ 16'h0001;
            avm_readdatavalid = 1'b1;
            avm_readdata = rdata;
            rd_pend = 1'b0;
            last_evt_cyc = cyc;
            if (rdata != exp_word(64'(rd_addr), m_pat)) begin
              if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
              if (!m_first_set) begin
                m_first_set = 1'b1; m_first_addr = rd_addr; m_first_data = rdata;
              end
            end
          end
        end
        if (prev_hold)
          check("hold", {avm_write, avm_read, avm_address, avm_writedata}, {p_wr, p_rd, p_addr, p_data});
        wq = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_waitrequest = wq;
        if (avm_write || avm_read) begin
          if (!m_bus_ok) check("no_cmd", {avm_write, avm_read}, 2'b00);
          if (avm_read && !prev_hold) check("rd_issue", cyc, last_evt_cyc + 1);
          if (!wq && avm_write) begin
            check("wr_addr", avm_address, m_wr_next);
            check("wr_data", avm_writedata, exp_word(m_wr_next, m_pat));
            if (!rand_wait) check("wr_b2b", cyc, m_start_cyc + 1 + m_wr_idx);
            mem[avm_address] = avm_writedata;
            m_wr_next = m_wr_next + 64'd1;
            m_wr_idx++;
            last_evt_cyc = cyc;
            if (spur_en && m_wr_idx == 1) spur_next = 1'b1;
          end
          if (!wq && avm_read) begin
            check("rd_addr", avm_address, m_rd_next);
            check("rd_after_wr", m_wr_next, m_hi + 64'd1);
            rd_pend = 1'b1; rd_lat = m_lat; rd_addr = avm_address;
            m_rd_next = m_rd_next + 64'd1;
            m_acc_cyc = cyc;
          end
        end
        prev_hold = (avm_write || avm_read) && wq;
        p_wr = avm_write; p_rd = avm_read; p_addr = avm_address; p_data = avm_writedata;
      end
    end
  end

  task automatic start_run(input logic [17:0] lo, input logic [17:0] hi, input logic [1:0] pat,
                           input bit rw, input int lat, input bit inj, input bit nr);
    @(negedge clk);
    m_hi = 64'(hi); m_wr_next = 64'(lo); m_rd_next = 64'(lo); m_pat = pat;
    m_wr_idx = 0; m_err = 16'd0; m_first_set = 1'b0; m_first_addr = '0; m_first_data = '0;
    rand_wait = rw; m_lat = lat; inject = inj; no_resp = nr; rd_pend = 1'b0;
    m_bus_ok = (hi >= lo); m_start_cyc = cyc; last_evt_cyc = -10; m_acc_cyc = -10;
    start = 1'b1; addr_lo = lo; addr_hi = hi; pattern = pat;
    @(negedge clk);
    start = 1'b0;
    check("busy", busy, 1'b1);
  endtask

  task automatic wait_done(input bit to, input bit cfg);
    int n;
    int exp_cyc;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: done_o not seen within 3000 cycles");
    end else begin
      exp_cyc = cfg ? m_start_cyc + 1 : (to ? m_acc_cyc + 16 : last_evt_cyc + 1);
      check("done_cyc", cyc, exp_cyc);
      check("pass", pass, (!to && !cfg && m_err == 16'd0));
      check("timeout", timeout, to);
      check("cfg_err", cfg_err, cfg);
      check("err_cnt", err_cnt, m_err);
      check("first_addr", first_err_addr, m_first_addr);
      check("first_data", first_err_data, m_first_data);
      check("cmd_low", {avm_write, avm_read}, 2'b00);
      @(negedge clk);
      check("done_pulse", {done, busy}, 2'b00);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {busy, done, pass, cfg_err, timeout, avm_write, avm_read, err_cnt, avm_writedata}, 64'd0);
    check({tag, "_addrs"}, {avm_address, first_err_addr, first_err_data}, 64'd0);
  endtask

  initial begin : main
    start = 1'b0; addr_lo = '0; addr_hi = '0; pattern = 2'd0;
    m_bus_ok = 1'b0; spur_en = 1'b0; rand_wait = 1'b0; no_resp = 1'b0; inject = 1'b0;
    m_lat = 2; m_hi = 64'd0; m_wr_next = 64'd0; m_rd_next = 64'd0; m_pat = 2'd0;

    // Pin the model against hand-computed words.
    check("pin_naddr", exp_word(64'd5, 2'd1), 16'hFFFA);
    check("pin_walk", exp_word(64'h3FFF3, 2'd2), 16'h0008);
    check("pin_chk_odd", exp_word(64'd7, 2'd3), 16'hAAAA);
    check("pin_chk_even", exp_word(64'd6, 2'd3), 16'h5555);

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic pass, with a stray readdatavalid during the write phase.
    spur_en = 1'b1;
    start_run(18'd0, 18'd3, 2'd0, 1'b0, 2, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0);
    spur_en = 1'b0;
    check("basic_pass_lit", {pass, err_cnt}, {1'b1, 16'h0000});

    // Injected mismatch at address 5.
    start_run(18'd0, 18'd15, 2'd1, 1'b0, 2, 1'b1, 1'b0);
    wait_done(1'b0, 1'b0);
    check("inj_lit", {pass, err_cnt, first_err_addr, first_err_data},
          {1'b0, 16'd1, 18'd5, 16'hFFFB});

    // Random waitrequest at the top of the address space; ignored restart.
    start_run(18'h3FFF0, 18'h3FFFF, 2'd2, 1'b1, 1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; addr_lo = 18'd0; addr_hi = 18'd0; pattern = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 1'b0);
    check("rw_pass_lit", pass, 1'b1);

    // Missing read response.
    start_run(18'd0, 18'd3, 2'd0, 1'b0, 2, 1'b0, 1'b1);
    wait_done(1'b1, 1'b0);
    no_resp = 1'b0;

    // Invalid window: no bus cycles at all.
    start_run(18'd10, 18'd9, 2'd0, 1'b0, 2, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset during the write phase, then a clean checkerboard run.
    start_run(18'd0, 18'd15, 2'd0, 1'b0, 2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 check("pre_rst_wr", avm_write, 1'b1);
    rst_n = 1'b0;
    m_bus_ok = 1'b0;
    #1 check_all_zero("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(18'd0, 18'd7, 2'd3, 1'b0, 3, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0);
    check("rst_rerun_lit", {pass, err_cnt}, {1'b1, 16'h0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
